// File: rtl/band_led_sched.sv
// band_led_sched: time-multiplexes one shared mag2therm converter across NUM_BANDS band
// magnitudes. All bands are snapshotted on vld, converted one at a time and published to the
// LED bank together, so a partial update is never visible.
// Optional build macro: PEAK_HOLD_EN (per-band peak hold with a scan-count decay).
module band_led_sched #(
   parameter int unsigned NUM_BANDS = 5,
   parameter int unsigned HOLD_UPD  = 8
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     vld,
   input  logic [15*NUM_BANDS-1:0]  band_mag,
   input  logic [8:0]               therm_in,
   output logic [14:0]              mag_sel,
   output logic [9*NUM_BANDS-1:0]   led_bands,
   output logic                     done,
   output logic                     busy
);

   localparam int unsigned IdxW = (NUM_BANDS > 1) ? $clog2(NUM_BANDS) : 1;
   localparam logic [IdxW-1:0] LastIdx = IdxW'(NUM_BANDS - 1);

   // The hold counter is a fixed 8 bits wide, which bounds HOLD_UPD.
   if (NUM_BANDS == 0 || NUM_BANDS > 8 || HOLD_UPD > 255) begin : gen_param_err
      $error("band_led_sched: parameter out of range");
   end

   typedef enum logic [1:0] {StIdle, StLoad, StCapt, StDone} state_e;

   state_e                          state_q, state_d;
   logic [IdxW-1:0]                 idx_q, idx_d;
   logic                            pending_q, pending_d;
   logic [NUM_BANDS-1:0][14:0]      snap_q, snap_d;
   logic [14:0]                     mag_sel_q, mag_sel_d;
   logic [NUM_BANDS-1:0][8:0]       shadow_q, shadow_d;
   logic [NUM_BANDS-1:0][8:0]       led_q, led_d;
`ifdef PEAK_HOLD_EN
   logic [NUM_BANDS-1:0][7:0]       cnt_q, cnt_d;
   logic [8:0]                      half_v;
`endif

   // Next-state logic for the scan sequencer and all datapath registers.
   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      pending_d = pending_q;
      snap_d    = snap_q;
      mag_sel_d = mag_sel_q;
      shadow_d  = shadow_q;
      led_d     = led_q;
`ifdef PEAK_HOLD_EN
      cnt_d     = cnt_q;
      half_v    = '0;
`endif
      // A request that arrives mid-scan is remembered (one deep) for a rescan.
      if (vld && (state_q != StIdle)) begin
         pending_d = 1'b1;
      end

      unique case (state_q)
         StIdle: begin
            if (vld || pending_q) begin
               snap_d    = band_mag;
               idx_d     = '0;
               pending_d = 1'b0;
               state_d   = StLoad;
            end
         end
         StLoad: begin
            mag_sel_d = snap_q[idx_q];
            state_d   = StCapt;
         end
         StCapt: begin
            // therm_in is the converter's response to the registered mag_sel.
            shadow_d[idx_q] = therm_in;
            if (idx_q == LastIdx) begin
               state_d = StDone;
            end else begin
               idx_d   = idx_q + IdxW'(1);
               state_d = StLoad;
            end
         end
         StDone: begin
`ifdef PEAK_HOLD_EN
            for (int b = 0; b < NUM_BANDS; b++) begin
               if (shadow_q[b] >= led_q[b]) begin
                  led_d[b] = shadow_q[b];
                  cnt_d[b] = 8'(HOLD_UPD);
               end else if (cnt_q[b] != 8'd0) begin
                  cnt_d[b] = cnt_q[b] - 8'd1;
               end else begin
                  // Hold expired: fall by one LED per scan, but never below the live code.
                  half_v   = led_q[b] >> 1;
                  led_d[b] = (half_v > shadow_q[b]) ? half_v : shadow_q[b];
               end
            end
`else
            led_d = shadow_q;
`endif
            state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   // State and datapath registers; reset aborts any scan without publishing.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= StIdle;
         idx_q     <= '0;
         pending_q <= 1'b0;
         snap_q    <= '0;
         mag_sel_q <= '0;
         shadow_q  <= '0;
         led_q     <= '0;
`ifdef PEAK_HOLD_EN
         cnt_q     <= '0;
`endif
      end else begin
         state_q   <= state_d;
         idx_q     <= idx_d;
         pending_q <= pending_d;
         snap_q    <= snap_d;
         mag_sel_q <= mag_sel_d;
         shadow_q  <= shadow_d;
         led_q     <= led_d;
`ifdef PEAK_HOLD_EN
         cnt_q     <= cnt_d;
`endif
      end
   end

   // Outputs decode directly from registered state, so they are glitch-free.
   always_comb begin
      mag_sel   = mag_sel_q;
      led_bands = led_q;
      done      = (state_q == StDone);
      busy      = (state_q != StIdle);
   end

endmodule

// File: tb/tb_band_led_sched.sv
// tb_band_led_sched: directed bench for band_led_sched with a behavioural mag2therm model.
// Build with PEAK_HOLD_EN defined to exercise the peak-hold decay instead of the base scans.
module tb_band_led_sched;

   localparam int unsigned N = 5;

   logic                clk;
   logic                rst_n;
   logic                vld;
   logic [15*N-1:0]     band_mag;
   logic [8:0]          therm_in;
   logic [14:0]         mag_sel;
   logic [9*N-1:0]      led_bands;
   logic                done;
   logic                busy;

   int                  n_checks;
   int                  n_fail;
   int                  lat;
   int                  gap;
   int                  ndone;
   logic [14:0]         seen [0:39];

   // Thresholds of the bench's mag2therm model; one LED per threshold reached.
   localparam logic [14:0] Thr [9] = '{15'h0180, 15'h0300, 15'h0600, 15'h0C00, 15'h1800,
                                       15'h2800, 15'h4000, 15'h6000, 15'h7FFF};

   localparam logic [15*N-1:0] MagT2 = {15'h7FFF, 15'h2000, 15'h0180, 15'h017F, 15'h0000};
   localparam logic [9*N-1:0]  ExpT2 = {9'h1FF, 9'h01F, 9'h001, 9'h000, 9'h000};
   localparam logic [15*N-1:0] MagT4 = {15'h0000, 15'h0300, 15'h0C00, 15'h4000, 15'h7FFF};
   localparam logic [9*N-1:0]  ExpT4 = {9'h000, 9'h003, 9'h00F, 9'h07F, 9'h1FF};
   localparam logic [8:0]      ExpHold [12] = '{9'h1FF, 9'h1FF, 9'h1FF, 9'h0FF, 9'h07F, 9'h03F,
                                                9'h01F, 9'h00F, 9'h007, 9'h003, 9'h001, 9'h000};

   band_led_sched #(
      .NUM_BANDS (N),
      .HOLD_UPD  (2)
   ) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .vld       (vld),
      .band_mag  (band_mag),
      .therm_in  (therm_in),
      .mag_sel   (mag_sel),
      .led_bands (led_bands),
      .done      (done),
      .busy      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [8:0] m2t(input logic [14:0] m);
      logic [9:0] t;
      int         n;
      n = 0;
      for (int k = 0; k < 9; k++) begin
         if (m >= Thr[k]) n++;
      end
      t = (10'd1 << n) - 10'd1;
      return t[8:0];
   endfunction

   always_comb therm_in = m2t(mag_sel);

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Called at a falling edge. mode 0 plain, 1 disturb band 0 mid-scan,
   // 2 three extra vld pulses mid-scan, 3 vld raised in the done cycle.
   task automatic pulse_scan(input int mode, output int l);
      vld = 1'b1;
      @(negedge clk);
      vld = 1'b0;
      l = 1;
      seen[1] = mag_sel;
      if (mode == 1) band_mag[14:0] = 15'h7FFF;
      while (!done && l < 39) begin
         @(negedge clk);
         l++;
         seen[l] = mag_sel;
         vld = (mode == 2) && (l == 2 || l == 4 || l == 6);
      end
      if (mode == 3) vld = 1'b1;
   endtask

   task automatic wait_done(output int n);
      n = 0;
      do begin
         @(negedge clk);
         vld = 1'b0;
         n++;
      end while (!done && n < 60);
   endtask

   task automatic count_done(input int cycles, output int n);
      n = 0;
      for (int i = 0; i < cycles; i++) begin
         @(negedge clk);
         if (done) n++;
      end
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      rst_n    = 1'b0;
      vld      = 1'b0;
      band_mag = '0;
      repeat (3) @(negedge clk);
      check("rst_led", 64'(led_bands), 64'd0);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_done", 64'(done), 64'd0);
      check("rst_magsel", 64'(mag_sel), 64'd0);
      rst_n = 1'b1;
      @(negedge clk);

`ifdef PEAK_HOLD_EN
      band_mag = '0;
      band_mag[14:0] = 15'h7FFF;
      for (int s = 0; s < 12; s++) begin
         pulse_scan(0, lat);
         band_mag[14:0] = 15'h0000;
         check("hold_lat", 64'(lat), 64'd11);
         @(negedge clk);
         check($sformatf("hold_scan%0d", s + 1), 64'(led_bands[8:0]), 64'(ExpHold[s]));
      end
      check("hold_others", 64'(led_bands[9*N-1:9]), 64'd0);
`else
      // Single scan: latency, mag_sel order and published codes.
      band_mag = MagT2;
      pulse_scan(0, lat);
      check("t2_lat", 64'(lat), 64'd11);
      for (int b = 0; b < N; b++) begin
         check($sformatf("t5_order_b%0d_a", b), 64'(seen[2 + 2 * b]), 64'(MagT2[15 * b +: 15]));
         check($sformatf("t5_order_b%0d_b", b), 64'(seen[3 + 2 * b]), 64'(MagT2[15 * b +: 15]));
      end
      @(negedge clk);
      check("t2_led", 64'(led_bands), 64'(ExpT2));
      check("t2_idle", 64'(busy), 64'd0);

      // Input changes during a scan are not seen.
      pulse_scan(1, lat);
      check("t3_lat", 64'(lat), 64'd11);
      @(negedge clk);
      check("t3_led", 64'(led_bands), 64'(ExpT2));

      // Several mid-scan requests collapse into exactly one rescan.
      band_mag = MagT4;
      pulse_scan(2, lat);
      check("t4_lat", 64'(lat), 64'd11);
      wait_done(gap);
      check("t4_gap", 64'(gap), 64'd12);
      @(negedge clk);
      check("t4_led", 64'(led_bands), 64'(ExpT4));
      count_done(30, ndone);
      check("t4_extra", 64'(ndone), 64'd0);

      // Request in the done cycle.
      pulse_scan(3, lat);
      check("t4b_lat", 64'(lat), 64'd11);
      wait_done(gap);
      check("t4b_gap", 64'(gap), 64'd12);
      count_done(30, ndone);
      check("t4b_extra", 64'(ndone), 64'd0);

      // Reset while capturing band 2 (cycle 6 of the scan).
      band_mag = MagT2;
      vld = 1'b1;
      @(negedge clk);
      vld = 1'b0;
      repeat (5) @(negedge clk);
      check("t1_busy_pre", 64'(busy), 64'd1);
      rst_n = 1'b0;
      #1;
      check("t1_led", 64'(led_bands), 64'd0);
      check("t1_busy", 64'(busy), 64'd0);
      check("t1_done", 64'(done), 64'd0);
      check("t1_magsel", 64'(mag_sel), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      count_done(30, ndone);
      check("t1_nodone", 64'(ndone), 64'd0);
      check("t1_led_post", 64'(led_bands), 64'd0);

      // Normal operation after the aborted scan.
      pulse_scan(0, lat);
      check("rec_lat", 64'(lat), 64'd11);
      @(negedge clk);
      check("rec_led", 64'(led_bands), 64'(ExpT2));
`endif

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
